// File: rtl/ci_if_pkg.sv
// rtl/ci_if_pkg.sv - shared state encoding and defaults for the CDC channel arbiter
package ci_if_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_ISSUE = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_DONE  = 3'd3;
    localparam state_t ST_ERR   = 3'd4;

    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 200;

endpackage

// File: rtl/ci_rr_pick.sv
// rtl/ci_rr_pick.sv - combinational round-robin selector: first set request at or above ptr, with wrap
module ci_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int                 j;
    logic [IDX_W-1:0]   jj;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            jj = IDX_W'(j);
            if (!valid && req[jj]) begin
                valid   = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/ci_if_cdc_arb.sv
// rtl/ci_if_cdc_arb.sv - round-robin sequencer sharing one pulse-handshake CDC channel
// Each grant issues one master-enable pulse, then waits for ready or timeout.
module ci_if_cdc_arb
    import ci_if_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int IDX_W   = 2,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             i_mclk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_rdy,
    output logic             o_men,
    output logic             o_ena_m,
    output logic             o_ena_ack,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic [N_REQ-1:0] o_done,
    output logic [N_REQ-1:0] o_err,
    output logic             o_busy
);

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;
    logic               ena_ack_q, ena_ack_d;

    logic [N_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    ci_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (i_req),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge i_mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_en && pick_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // ready takes priority over a timeout landing in the same cycle
                if (i_rdy) begin
                    state_d = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_men     = (state_q == ST_ISSUE);
        o_ena_m   = (state_q == ST_ISSUE);
        o_ena_ack = ena_ack_q;
        o_gnt     = gnt_q;
        o_idx     = idx_q;
        o_done    = (state_q == ST_DONE) ? gnt_q : '0;
        o_err     = (state_q == ST_ERR)  ? gnt_q : '0;
        o_busy    = (state_q != ST_IDLE);
    end

    always_comb begin
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ena_ack_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (i_en && pick_valid) begin
                    gnt_d = pick_gnt;
                    idx_d = pick_idx;
                end
            end
            ST_ISSUE: cnt_d = '0;
            ST_WAIT:  cnt_d = cnt_q + TO_W'(1);
            ST_DONE, ST_ERR: begin
                gnt_d = '0;
                ptr_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_mclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            ena_ack_q <= 1'b0;
        end else begin
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            ena_ack_q <= ena_ack_d;
        end
    end

endmodule

// File: tb/tb_ci_if_cdc_arb.sv
// tb/tb_ci_if_cdc_arb.sv - directed scoreboard bench for the CDC channel arbiter
module tb_ci_if_cdc_arb;

    localparam int TO = 12;

    typedef struct packed {
        logic       is_err;
        logic [1:0] idx;
    } cmp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic       rdy;
    logic       men, ena_m, ena_ack, busy;
    logic [3:0] gnt, done, err;
    logic [1:0] idx;

    int   errors = 0;
    int   checks = 0;
    int   gnt_exp[$];
    cmp_t cmp_exp[$];

    ci_if_cdc_arb #(
        .N_REQ   (4),
        .IDX_W   (2),
        .TO_W    (8),
        .TIMEOUT (TO)
    ) dut (
        .i_mclk    (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_req     (req),
        .i_rdy     (rdy),
        .o_men     (men),
        .o_ena_m   (ena_m),
        .o_ena_ack (ena_ack),
        .o_gnt     (gnt),
        .o_idx     (idx),
        .o_done    (done),
        .o_err     (err),
        .o_busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [17:0] all_out();
        return {men, ena_m, ena_ack, busy, gnt, idx, done, err};
    endfunction

    // scoreboard side: grants checked on every master-enable pulse, completions on every done/err pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (men) begin
                if (gnt_exp.size() == 0) begin
                    chk("unexpected_men", 32'(gnt), 32'h0);
                end else begin
                    int e;
                    e = gnt_exp.pop_front();
                    chk("sb_gnt", 32'(gnt), 32'(1 << e));
                    chk("sb_idx", 32'(idx), 32'(e));
                    chk("sb_ena_m", 32'(ena_m), 32'h1);
                end
            end
            if ((done | err) != 4'b0) begin
                if (cmp_exp.size() == 0) begin
                    chk("unexpected_completion", 32'({done, err}), 32'h0);
                end else begin
                    cmp_t c;
                    logic [3:0] oh;
                    c  = cmp_exp.pop_front();
                    oh = 4'(1 << c.idx);
                    chk("sb_done_err", 32'({done, err}), c.is_err ? 32'({4'b0, oh}) : 32'({oh, 4'b0}));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 4'b0;
        rdy   = 1'b0;

        // reset values
        tick(3);
        chk("reset_outputs", 32'(all_out()), 32'h0);
        rst_n = 1'b1;
        tick(1);
        chk("ena_ack_after_reset", 32'(ena_ack), 32'h1);
        chk("idle_after_reset", 32'(busy), 32'h0);

        // single requester, ready 10 cycles after the enable pulse
        en  = 1'b1;
        req = 4'b0010;
        gnt_exp.push_back(1);
        tick(1);
        chk("single_men", 32'(men), 32'h1);
        chk("single_gnt", 32'(gnt), 32'h2);
        tick(10);
        chk("single_wait_men_low", 32'(men), 32'h0);
        rdy = 1'b1;
        cmp_exp.push_back('{is_err: 1'b0, idx: 2'd1});
        tick(1);
        chk("single_done", 32'(done), 32'h2);
        rdy = 1'b0;
        req = 4'b0;
        tick(1);
        chk("single_idle", 32'(busy), 32'h0);
        chk("single_gnt_clear", 32'(gnt), 32'h0);

        // fairness: all requesting, pointer now at 2
        req = 4'b1111;
        for (int k = 0; k < 5; k++) gnt_exp.push_back((2 + k) % 4);
        tick(1);
        for (int k = 0; k < 5; k++) begin
            chk("rr_men", 32'(men), 32'h1);
            chk("rr_idx", 32'(idx), 32'((2 + k) % 4));
            tick(1);
            rdy = 1'b1;
            cmp_exp.push_back('{is_err: 1'b0, idx: 2'((2 + k) % 4)});
            tick(1);
            rdy = 1'b0;
            chk("rr_done", 32'(done), 32'(1 << ((2 + k) % 4)));
            if (k == 4) req = 4'b0;
            tick(1);
            chk("rr_idle", 32'(busy), 32'h0);
            tick(1);
        end
        chk("rr_no_extra", 32'(busy), 32'h0);

        // timeout: pointer at 3, requester 0 wins by wrap
        req = 4'b0001;
        gnt_exp.push_back(0);
        cmp_exp.push_back('{is_err: 1'b1, idx: 2'd0});
        tick(1);
        chk("to_men", 32'(men), 32'h1);
        tick(TO);
        chk("to_not_yet", 32'(err), 32'h0);
        chk("to_busy", 32'(busy), 32'h1);
        tick(1);
        chk("to_err", 32'(err), 32'h1);
        chk("to_no_done", 32'(done), 32'h0);
        req = 4'b0;
        tick(1);
        rdy = 1'b1;
        tick(1);
        rdy = 1'b0;
        chk("late_rdy_no_done", 32'(done), 32'h0);
        chk("late_rdy_idle", 32'(busy), 32'h0);

        // ready on the same cycle as the timeout condition
        req = 4'b0100;
        gnt_exp.push_back(2);
        cmp_exp.push_back('{is_err: 1'b0, idx: 2'd2});
        tick(1);
        tick(TO);
        rdy = 1'b1;
        chk("coll_no_err_yet", 32'(err), 32'h0);
        tick(1);
        chk("coll_done_wins", 32'({done, err}), 32'h40);
        rdy = 1'b0;
        req = 4'b0;
        tick(1);

        // reset mid-transfer, then re-grant from index 0
        req = 4'b1000;
        gnt_exp.push_back(3);
        tick(1);
        tick(3);
        chk("pre_reset_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", 32'(all_out()), 32'h0);
        req = 4'b1001;
        tick(2);
        rst_n = 1'b1;
        gnt_exp.push_back(0);
        tick(1);
        chk("post_reset_men", 32'(men), 32'h1);
        chk("post_reset_idx", 32'(idx), 32'h0);
        tick(1);
        rdy = 1'b1;
        cmp_exp.push_back('{is_err: 1'b0, idx: 2'd0});
        tick(1);
        rdy = 1'b0;
        req = 4'b0;
        tick(1);

        // enable gating
        en  = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("en_low_no_issue", 32'({men, busy}), 32'h0);
        end
        en = 1'b1;
        gnt_exp.push_back(1);
        tick(1);
        chk("en_high_men", 32'(men), 32'h1);
        tick(1);
        en = 1'b0;
        tick(2);
        rdy = 1'b1;
        cmp_exp.push_back('{is_err: 1'b0, idx: 2'd1});
        tick(1);
        rdy = 1'b0;
        chk("en_drop_done", 32'(done), 32'h2);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("en_drop_hold_idle", 32'({men, busy}), 32'h0);
        end
        en = 1'b1;
        gnt_exp.push_back(2);
        tick(1);
        chk("en_resume_idx", 32'(idx), 32'h2);
        tick(1);
        rdy = 1'b1;
        req = 4'b0;
        cmp_exp.push_back('{is_err: 1'b0, idx: 2'd2});
        tick(1);
        rdy = 1'b0;
        chk("req_drop_still_done", 32'(done), 32'h4);
        tick(2);

        chk("gnt_queue_drained", 32'(gnt_exp.size()), 32'h0);
        chk("cmp_queue_drained", 32'(cmp_exp.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ci_if_cdc_arb.md
# ci_if_cdc_arb

Round-robin arbiter and sequencer that shares one pulse-handshake CDC channel among N_REQ requesters in the master clock domain. Each granted requester gets exactly one channel transfer: the block raises the channel's master enable, waits for the returned ready pulse, and reports completion or timeout back to that requester. It sits between the master-domain request sources and the CDC channel's master-side controls.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- IDX_W, 2: width of the grant index, equal to ceil(log2(N_REQ)).
- TO_W, 8: width of the timeout counter.
- TIMEOUT, 200: cycles in WAIT before the transfer is abandoned, 1..2^TO_W-1.
- i_mclk in 1: the single clock, rising edge.
- i_rst_n in 1: asynchronous, active-low reset.
- i_en in 1: arbitration enable. When low, no new grant is issued; an in-flight transfer completes normally.
- i_req in N_REQ: level request per requester. Held until that requester's o_done or o_err bit.
- i_rdy in 1: ready pulse from the channel, one cycle per completed round trip.
- o_men out 1: master-enable pulse to the channel.
- o_ena_m out 1: master-side load enable to the channel.
- o_ena_ack out 1: ack-path enable to the channel. Constant 1 out of reset.
- o_gnt out N_REQ: one-hot grant, held from ISSUE through DONE/ERR.
- o_idx out IDX_W: binary index of the current or last grant.
- o_done out N_REQ: one-cycle one-hot completion pulse.
- o_err out N_REQ: one-cycle one-hot timeout pulse.
- o_busy out 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: default state.
  - ISSUE: one cycle.
  - WAIT: holds until ready or timeout.
  - DONE: one cycle.
  - ERR: one cycle.
- IDLE → ISSUE when i_en=1 and |i_req. The winner is the first set bit scanning upward from rr_ptr, with wrap.
  - The grant and index register on this transition.
- ISSUE: o_ena_m=1 and o_men=1 for exactly one cycle. Go to WAIT. Clear the timeout counter.
- WAIT: o_ena_m=0, o_men=0. The counter increments every cycle.
  - If i_rdy=1, go to DONE.
  - Else, if the counter equals TIMEOUT-1, go to ERR.
  - If i_rdy and the timeout condition occur on the same cycle, i_rdy wins and the state goes to DONE.
- DONE: pulse o_done[idx]. Set rr_ptr = idx+1, wrapping N_REQ-1 to 0. Go to IDLE.
- ERR: pulse o_err[idx]. Advance rr_ptr the same way as DONE. Go to IDLE.
- An i_rdy that arrives outside WAIT (a late ready after a timeout) is ignored and produces no output.
- Deassertion of i_req by the granted requester during WAIT does not abort the transfer; completion is still reported.
- A requester whose request is still high in the cycle after its own DONE is eligible again, but only after the other pending requesters (round-robin order).
- i_en deasserted in WAIT has no effect until the state returns to IDLE.

## Timing
- Reset values:
  - State IDLE, rr_ptr=0, counter=0.
  - o_men=0, o_ena_m=0, o_ena_ack=0 during reset, then 1 from the first clock edge after release.
  - o_gnt=0, o_idx=0, o_done=0, o_err=0, o_busy=0.
- Request-to-issue latency: a request sampled in IDLE produces o_men in the next cycle.
- Ready-to-completion latency: i_rdy at cycle t produces o_done at cycle t+1. The block is in IDLE at t+2 and can issue again at t+3.
- Timeout: o_err is asserted exactly TIMEOUT+1 cycles after the o_men cycle.
- All outputs are registered or decoded from state only; there are no combinational paths from i_req or i_rdy to outputs.
- Reset asserted mid-transfer returns everything to reset values immediately. No done or error pulse is emitted for the aborted transfer.

## Structure
- Shared package ci_if_pkg holds:
  - the state encoding constants (IDLE/ISSUE/WAIT/DONE/ERR, 3-bit),
  - the default N_REQ and TIMEOUT values.
- One natural sub-module, ci_rr_pick: a combinational round-robin selector. Inputs are the request vector and the pointer; outputs are a one-hot grant, a binary index and a valid flag. It is reusable by other arbiters.

## Test plan
- Single requester: i_req=4'b0010 → o_men pulses 1 cycle later with o_gnt=0010 and o_idx=1; i_rdy 10 cycles later → o_done=0010 one cycle after i_rdy; rr_ptr=2.
- Fairness: i_req=4'b1111 held, and each transfer acks immediately → grants in order 0,1,2,3,0. No requester is granted twice before all four are served.
- Timeout: TIMEOUT=5, no i_rdy → o_err[idx] is asserted 6 cycles after o_men. A late i_rdy while IDLE produces no o_done.
- Same-cycle collision: i_rdy asserted in the cycle where the counter reaches TIMEOUT-1 → o_done is asserted and o_err stays 0.
- Reset in WAIT: i_rst_n low mid-WAIT → all outputs are at reset values within the same cycle. After release, a pending request is re-granted starting from index 0.
- Enable gating: i_en=0 with i_req=1111 → no o_men. Dropping i_en during WAIT still yields o_done; no new o_men until i_en=1.
